row_serializer: RTL and testbench
=================================

// Module: row_serializer
// PURPOSE
//  Downstream consumer of the 10x16-bit result-row register bank (ten parallel 16-bit words).
//  On start, snapshots the whole row into a shadow buffer and streams it one word per beat.
//  Uses a valid/ready handshake towards the output/memory-write side of the matrix multiplier.
//  Frees the register bank for reload as soon as the snapshot is taken.
// PARAMETERS
//  WIDTH    16  bits per word
//  N_WORDS  10  words per row (>=1)
//  IDX_W    4   width of out_idx, >= clog2(N_WORDS)
// PORTS
//  CLK        in   1              clock, all state updates on rising edge
//  reset      in   1              synchronous, active-high
//  din_flat   in   WIDTH*N_WORDS  row from bank; word k = din_flat[WIDTH*k +: WIDTH] (k=0 is Dout1)
//  start      in   1              request to snapshot din_flat and stream it
//  busy       out  1              high in SEND and DONE states
//  out_data   out  WIDTH          current word
//  out_idx    out  IDX_W          index of current word, 0..N_WORDS-1
//  out_valid  out  1              out_data/out_idx/out_last are valid
//  out_ready  in   1              consumer accepts the beat when out_valid && out_ready
//  out_last   out  1              current beat is word N_WORDS-1
//  done       out  1              one-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  Reset (sampled at a rising edge): state=IDLE, idx=0, shadow=0.
//   Outputs after reset: busy, out_valid, out_last and done are 0; out_data=0; out_idx=0.
//   Reset has priority over every other input, including in mid-stream.
//  FSM states: IDLE, SEND, DONE.
//   IDLE: start=1 at edge t captures din_flat into shadow, sets idx=0 and moves to SEND.
//         out_valid=1 from t+1. start=0 keeps the block in IDLE.
//   SEND: out_valid=1 and out_data=shadow[idx].
//         On out_valid && out_ready: if idx==N_WORDS-1, go to DONE and clear idx to 0;
//         otherwise idx increments by 1.
//         With out_ready=0, state, idx and out_data hold; no skipped or duplicated words.
//   DONE: done=1 and out_valid=0 for exactly one cycle, then unconditional return to IDLE.
//  start is ignored in SEND and DONE; no queuing.
//   The earliest restart is start in the first IDLE cycle, giving N_WORDS+2 cycles per row
//   at full throughput.
//  din_flat is sampled only at the capture edge. Later changes never affect the stream in flight.
//   The bank updates on the falling edge, so din_flat is stable at the rising edge.
//  Output derivation:
//   out_last = (state==SEND) && (idx==N_WORDS-1).
//   out_idx = idx.
//   out_data = shadow[idx] in SEND, 0 otherwise.
//  out_valid, out_data, out_last and out_idx come from registered state only;
//   there is no combinational path from out_ready.
//  N_WORDS=1: a single beat with out_last=1 on it.
// TESTING
//  1 Reset: hold reset 2 cycles with start=1 -> all outputs 0, state stays IDLE.
//  2 Full throughput: word k=16'h0100+k, start pulse at t, out_ready=1 ->
//    beats 0x0100..0x0109 at t+1..t+10 with idx 0..9; out_last only at t+10; done=1 at t+11;
//    busy=0 at t+12.
//  3 Backpressure: out_ready=0 on the cycles where idx=3,4,5 would advance ->
//    out_data=0x0103 holds steady, then 0x0104..0x0109 follow with no gaps or repeats;
//    total 13 beat-cycles.
//  4 Snapshot isolation: after capture, change din_flat to all 16'hFFFF and pulse start mid-stream ->
//    the original words stream out, start is ignored, done pulses once.
//  5 Reset mid-stream at idx=4 -> next cycle out_valid=0, busy=0, out_idx=0, no done pulse;
//    a new start replays from idx 0.
//  6 Back-to-back: start held high continuously -> a new row is captured on the first IDLE cycle
//    after each done; each row takes exactly 12 cycles from capture to capture.

Source files
------------

// File: rtl/row_serializer_if.sv
// Row handshake bundle: the parallel row and start come in, the word stream and status go out.
interface row_serializer_if #(
    parameter int WIDTH   = 16,
    parameter int N_WORDS = 10,
    parameter int IDX_W   = 4
);
    logic [WIDTH*N_WORDS-1:0] din_flat;
    logic                     start;
    logic                     busy;
    logic [WIDTH-1:0]         out_data;
    logic [IDX_W-1:0]         out_idx;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic                     done;

    modport master (
        input  din_flat, start, out_ready,
        output busy, out_data, out_idx, out_valid, out_last, done
    );

    modport slave (
        output din_flat, start, out_ready,
        input  busy, out_data, out_idx, out_valid, out_last, done
    );
endinterface

// File: rtl/row_serializer.sv
// Snapshots a WIDTH x N_WORDS row on start and streams it one word per beat; first beat one cycle after capture.
// out_ready low holds the current word; outputs are registered-state only, so there is no path from out_ready.
module row_serializer #(
    parameter int WIDTH   = 16,
    parameter int N_WORDS = 10,
    parameter int IDX_W   = 4
) (
    input  logic              CLK,
    input  logic              reset,
    row_serializer_if.master  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] shadow [N_WORDS];

    logic in_send;
    logic beat;

    assign in_send = (state == S_SEND);
    assign beat    = in_send && bus.out_ready;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
            for (int k = 0; k < N_WORDS; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        // The bank is free to reload from the next cycle on.
                        for (int k = 0; k < N_WORDS; k++) begin
                            shadow[k] <= bus.din_flat[WIDTH*k +: WIDTH];
                        end
                        idx   <= '0;
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (beat) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_DONE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    assign bus.busy      = (state == S_SEND) || (state == S_DONE);
    assign bus.done      = (state == S_DONE);
    assign bus.out_valid = in_send;
    assign bus.out_last  = in_send && (idx == LAST_IDX);
    assign bus.out_idx   = idx;
    assign bus.out_data  = in_send ? shadow[idx] : '0;
endmodule

// File: tb/tb_row_serializer.sv
// Randomized bench for row_serializer: stream traces are checked against a word-queue reference model.
module tb_row_serializer;
    localparam int WIDTH   = 16;
    localparam int N_WORDS = 10;
    localparam int IDX_W   = 4;
    localparam int ROW_W   = WIDTH * N_WORDS;

    logic CLK = 1'b0;
    logic reset;

    row_serializer_if #(.WIDTH(WIDTH), .N_WORDS(N_WORDS), .IDX_W(IDX_W)) bus ();

    row_serializer #(.WIDTH(WIDTH), .N_WORDS(N_WORDS), .IDX_W(IDX_W)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Trace of one streamed row, filled by collect().
    logic [ROW_W-1:0]         r_row;
    logic [IDX_W*N_WORDS-1:0] r_idx;
    logic [N_WORDS-1:0]       r_last;
    int                       r_nacc, r_valid, r_done_obs, r_done_cnt, r_hold;
    logic                     r_idle_busy;
    bit                       r_timeout;
    bit                       ready_log[$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] w;
        for (int k = 0; k < N_WORDS; k++) w[WIDTH*k +: WIDTH] = WIDTH'($urandom);
        return w;
    endfunction

    function automatic logic [IDX_W*N_WORDS-1:0] exp_idx();
        logic [IDX_W*N_WORDS-1:0] v;
        for (int k = 0; k < N_WORDS; k++) v[IDX_W*k +: IDX_W] = IDX_W'(k);
        return v;
    endfunction

    function automatic logic [N_WORDS-1:0] exp_last();
        logic [N_WORDS-1:0] v;
        v = '0;
        v[N_WORDS-1] = 1'b1;
        return v;
    endfunction

    // Reference: the row is a queue of N_WORDS words drained by each ready cycle once
    // streaming begins; done shows on the observation after the final word is taken.
    function automatic int model_done_obs();
        int rem;
        rem = N_WORDS;
        foreach (ready_log[j]) begin
            if (rem > 0 && ready_log[j]) begin
                rem--;
                if (rem == 0) return j + 2;
            end
        end
        return -1;
    endfunction

    task automatic start_row(input logic [ROW_W-1:0] row);
        bus.din_flat = row;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    // Observes from the first cycle after capture until one cycle past done.
    task automatic collect(input int ready_pct, input int stall_from, input int stall_len, input int poison_obs);
        logic             pv;
        logic [WIDTH-1:0] pd;
        logic [IDX_W-1:0] pi;
        bit               r;
        r_row = '0; r_idx = '0; r_last = '0;
        r_nacc = 0; r_valid = 0; r_done_obs = 0; r_done_cnt = 0; r_hold = 0;
        r_idle_busy = 1'b1; r_timeout = 1'b1;
        ready_log.delete();
        pv = 1'b0; pd = '0; pi = '0;
        for (int obs = 1; obs <= 400; obs++) begin
            if (bus.done) begin
                r_done_cnt++;
                if (r_done_obs == 0) r_done_obs = obs;
            end
            if (r_done_obs != 0 && obs == r_done_obs + 1) begin
                r_idle_busy = bus.busy;
                r_timeout   = 1'b0;
                break;
            end
            if (bus.out_valid) begin
                r_valid++;
                if (pv && (bus.out_data !== pd || bus.out_idx !== pi)) r_hold++;
            end
            if (obs == poison_obs) begin
                bus.din_flat = '1;
                bus.start    = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (obs >= stall_from && obs < stall_from + stall_len) r = 1'b0;
            else r = ($urandom_range(99) < ready_pct);
            bus.out_ready = r;
            ready_log.push_back(r);
            if (bus.out_valid && r) begin
                if (r_nacc < N_WORDS) begin
                    r_row[WIDTH*r_nacc +: WIDTH] = bus.out_data;
                    r_idx[IDX_W*r_nacc +: IDX_W] = bus.out_idx;
                    r_last[r_nacc]               = bus.out_last;
                end
                r_nacc++;
            end
            pv = bus.out_valid && !r;
            pd = bus.out_data;
            pi = bus.out_idx;
            tick();
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1;
        bus.din_flat = rand_row();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            total_cnt++;
            if ({bus.busy, bus.out_valid, bus.out_last, bus.done, bus.out_data, bus.out_idx} !== '0)
                $display("FAIL reset_outputs cycle %0d: got busy=%b valid=%b last=%b done=%b data=%h idx=%0d, required all 0",
                         c, bus.busy, bus.out_valid, bus.out_last, bus.done, bus.out_data, bus.out_idx);
            else pass_cnt++;
        end
        reset = 1'b0;
        bus.start = 1'b0;
        tick();
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL reset_idle: got busy=%b valid=%b, required 0 0", bus.busy, bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_full_throughput();
        logic [ROW_W-1:0] row;
        for (int k = 0; k < N_WORDS; k++) row[WIDTH*k +: WIDTH] = WIDTH'(16'h0100 + k);
        start_row(row);
        collect(100, 0, 0, 0);
        total_cnt++;
        if (r_timeout !== 1'b0) $display("FAIL full_timeout: got no done, required done"); else pass_cnt++;
        total_cnt++;
        if (r_row !== row) $display("FAIL full_words: got %h, required %h", r_row, row); else pass_cnt++;
        total_cnt++;
        if (r_idx !== exp_idx()) $display("FAIL full_idx: got %h, required %h", r_idx, exp_idx()); else pass_cnt++;
        total_cnt++;
        if (r_last !== exp_last()) $display("FAIL full_last: got %b, required %b", r_last, exp_last()); else pass_cnt++;
        total_cnt++;
        if (r_valid !== 10) $display("FAIL full_beat_cycles: got %0d, required 10", r_valid); else pass_cnt++;
        total_cnt++;
        if (r_done_obs !== 11) $display("FAIL full_done_time: got t+%0d, required t+11", r_done_obs); else pass_cnt++;
        total_cnt++;
        if (r_done_cnt !== 1) $display("FAIL full_done_width: got %0d, required 1", r_done_cnt); else pass_cnt++;
        total_cnt++;
        if (r_idle_busy !== 1'b0) $display("FAIL full_busy_after: got %b, required 0", r_idle_busy); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [ROW_W-1:0] row;
        for (int k = 0; k < N_WORDS; k++) row[WIDTH*k +: WIDTH] = WIDTH'(16'h0100 + k);
        start_row(row);
        collect(100, 4, 3, 0);
        total_cnt++;
        if (r_row !== row) $display("FAIL bp_words: got %h, required %h", r_row, row); else pass_cnt++;
        total_cnt++;
        if (r_idx !== exp_idx()) $display("FAIL bp_idx: got %h, required %h", r_idx, exp_idx()); else pass_cnt++;
        total_cnt++;
        if (r_valid !== 13) $display("FAIL bp_beat_cycles: got %0d, required 13", r_valid); else pass_cnt++;
        total_cnt++;
        if (r_hold !== 0) $display("FAIL bp_hold: got %0d changes while stalled, required 0", r_hold); else pass_cnt++;
        total_cnt++;
        if (r_done_obs !== 14) $display("FAIL bp_done_time: got t+%0d, required t+14", r_done_obs); else pass_cnt++;
    endtask

    task automatic test_snapshot();
        logic [ROW_W-1:0] row;
        row = rand_row();
        start_row(row);
        collect(100, 0, 0, 3);
        total_cnt++;
        if (r_row !== row) $display("FAIL snap_words: got %h, required %h", r_row, row); else pass_cnt++;
        total_cnt++;
        if (r_done_cnt !== 1) $display("FAIL snap_done_count: got %0d, required 1", r_done_cnt); else pass_cnt++;
        total_cnt++;
        if (r_done_obs !== 11) $display("FAIL snap_done_time: got t+%0d, required t+11", r_done_obs); else pass_cnt++;
        total_cnt++;
        if (r_idle_busy !== 1'b0) $display("FAIL snap_no_restart: got busy=%b, required 0", r_idle_busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [ROW_W-1:0] row, row2;
        int dn;
        row = rand_row();
        start_row(row);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        total_cnt++;
        if (bus.out_idx !== IDX_W'(4) || bus.out_data !== row[WIDTH*4 +: WIDTH])
            $display("FAIL rmid_pre: got idx=%0d data=%h, required idx=4 data=%h", bus.out_idx, bus.out_data, row[WIDTH*4 +: WIDTH]);
        else pass_cnt++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.out_ready = 1'b0;
        total_cnt++;
        if ({bus.out_valid, bus.busy, bus.out_last, bus.done} !== 4'b0000)
            $display("FAIL rmid_flags: got valid=%b busy=%b last=%b done=%b, required 0 0 0 0",
                     bus.out_valid, bus.busy, bus.out_last, bus.done);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_idx !== '0 || bus.out_data !== '0)
            $display("FAIL rmid_idx_data: got idx=%0d data=%h, required 0 0", bus.out_idx, bus.out_data);
        else pass_cnt++;
        dn = 0;
        for (int c = 0; c < 3; c++) begin
            dn += int'(bus.done);
            tick();
        end
        total_cnt++;
        if (dn !== 0) $display("FAIL rmid_no_done: got %0d done pulses, required 0", dn); else pass_cnt++;
        row2 = rand_row();
        start_row(row2);
        collect(70, 0, 0, 0);
        total_cnt++;
        if (r_row !== row2) $display("FAIL rmid_replay_words: got %h, required %h", r_row, row2); else pass_cnt++;
        total_cnt++;
        if (r_idx !== exp_idx()) $display("FAIL rmid_replay_idx: got %h, required %h", r_idx, exp_idx()); else pass_cnt++;
        total_cnt++;
        if (r_done_obs !== model_done_obs())
            $display("FAIL rmid_replay_done: got t+%0d, required t+%0d", r_done_obs, model_done_obs());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [ROW_W-1:0] rows [3];
        logic [ROW_W-1:0] g;
        logic [WIDTH-1:0] got[$];
        int done_q[$];
        int vstart_q[$];
        logic pv;
        for (int r = 0; r < 3; r++) rows[r] = rand_row();
        bus.out_ready = 1'b1;
        bus.din_flat  = rows[0];
        bus.start     = 1'b1;
        tick();
        pv = 1'b0;
        for (int obs = 1; obs <= 36; obs++) begin
            if (bus.done) done_q.push_back(obs);
            if (bus.out_valid && !pv) vstart_q.push_back(obs);
            if (bus.out_valid) got.push_back(bus.out_data);
            pv = bus.out_valid;
            if (obs == 1)  bus.din_flat = rows[1];
            if (obs == 13) bus.din_flat = rows[2];
            if (obs == 25) bus.din_flat = rand_row();
            if (obs == 35) bus.start = 1'b0;
            tick();
        end
        total_cnt++;
        if (got.size() !== 30) $display("FAIL b2b_beat_count: got %0d, required 30", got.size()); else pass_cnt++;
        while (got.size() < 30) got.push_back('x);
        while (done_q.size() < 3) done_q.push_back(-1);
        while (vstart_q.size() < 3) vstart_q.push_back(-1);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N_WORDS; k++) g[WIDTH*k +: WIDTH] = got[r*N_WORDS + k];
            total_cnt++;
            if (g !== rows[r]) $display("FAIL b2b_row%0d: got %h, required %h", r, g, rows[r]); else pass_cnt++;
            total_cnt++;
            if (vstart_q[r] !== 1 + 12*r)
                $display("FAIL b2b_capture%0d: got first beat t+%0d, required t+%0d", r, vstart_q[r], 1 + 12*r);
            else pass_cnt++;
            total_cnt++;
            if (done_q[r] !== 11 + 12*r)
                $display("FAIL b2b_done%0d: got t+%0d, required t+%0d", r, done_q[r], 11 + 12*r);
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL b2b_stop: got busy=%b, required 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [ROW_W-1:0] row;
        for (int it = 0; it < 5; it++) begin
            row = rand_row();
            start_row(row);
            collect(int'($urandom_range(90, 30)), 0, 0, 0);
            total_cnt++;
            if (r_timeout !== 1'b0) $display("FAIL rnd%0d_timeout: got no done, required done", it); else pass_cnt++;
            total_cnt++;
            if (r_row !== row) $display("FAIL rnd%0d_words: got %h, required %h", it, r_row, row); else pass_cnt++;
            total_cnt++;
            if (r_idx !== exp_idx() || r_last !== exp_last())
                $display("FAIL rnd%0d_idx_last: got %h/%b, required %h/%b", it, r_idx, r_last, exp_idx(), exp_last());
            else pass_cnt++;
            total_cnt++;
            if (r_hold !== 0) $display("FAIL rnd%0d_hold: got %0d changes while stalled, required 0", it, r_hold); else pass_cnt++;
            total_cnt++;
            if (r_done_obs !== model_done_obs() || r_done_cnt !== 1)
                $display("FAIL rnd%0d_done: got t+%0d x%0d, required t+%0d x1", it, r_done_obs, r_done_cnt, model_done_obs());
            else pass_cnt++;
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        bus.din_flat  = '0;
        test_reset();
        test_full_throughput();
        test_backpressure();
        test_snapshot();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
